// File: rtl/superh16_ptw_arbiter_pkg.sv
// Shared types and widths for the ITLB/DTLB page-table-walker arbiter.
package superh16_ptw_arbiter_pkg;

    localparam int unsigned VADDR_WIDTH = 48;
    localparam int unsigned PADDR_WIDTH = 40;

    typedef enum logic {
        PTW_SRC_ITLB = 1'b0,
        PTW_SRC_DTLB = 1'b1
    } ptw_src_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } ptw_arb_state_e;

    typedef struct packed {
        logic [PADDR_WIDTH-1:0] paddr;
        logic [1:0]             page_size;
        logic [2:0]             perm;
        logic                   valid;
    } ptw_resp_t;

endpackage

// File: rtl/superh16_ptw_arbiter_if.sv
// Request/response channel between the arbiter (master) and the page-table walker (slave).
interface superh16_ptw_arbiter_if;
    import superh16_ptw_arbiter_pkg::*;

    logic                   walk_req_valid;
    logic                   walk_req_ready;
    logic [VADDR_WIDTH-1:0] walk_vaddr;
    logic                   walk_resp_valid;
    logic [PADDR_WIDTH-1:0] walk_paddr;
    logic [1:0]             walk_page_size;
    logic [2:0]             walk_perm;
    logic                   walk_fault;
    logic                   walk_abort;

    modport master (
        output walk_req_valid, walk_vaddr, walk_abort,
        input  walk_req_ready, walk_resp_valid, walk_paddr, walk_page_size, walk_perm, walk_fault
    );

    modport slave (
        input  walk_req_valid, walk_vaddr, walk_abort,
        output walk_req_ready, walk_resp_valid, walk_paddr, walk_page_size, walk_perm, walk_fault
    );

endinterface

// File: rtl/superh16_ptw_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; index 0 = ITLB, index 1 = DTLB. Reset favours index 0 first.
module superh16_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_gnt
);

    logic r_last;  // 1 when index 1 won the most recent grant

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= 1'b1;
        else if (i_upd && (|o_gnt))
            r_last <= o_gnt[1];
    end

endmodule

// File: rtl/superh16_ptw_arbiter.sv
// Shares one page-table walker between ITLB and DTLB: round-robin grant, one walk at a time, flush kill.
// Optional walk timeout/abort enabled by defining SUPERH16_PTW_TIMEOUT_EN.
module superh16_ptw_arbiter
  import superh16_ptw_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   itlb_req,
  input  logic [VADDR_WIDTH-1:0] itlb_vaddr,
  output logic                   itlb_ack,
  input  logic                   dtlb_req,
  input  logic [VADDR_WIDTH-1:0] dtlb_vaddr,
  output logic                   dtlb_ack,
  output logic [PADDR_WIDTH-1:0] resp_paddr,
  output logic [1:0]             resp_page_size,
  output logic                   resp_valid,
  output logic [2:0]             resp_perm,
  output logic                   walk_req_valid,
  input  logic                   walk_req_ready,
  output logic [VADDR_WIDTH-1:0] walk_vaddr,
  input  logic                   walk_resp_valid,
  input  logic [PADDR_WIDTH-1:0] walk_paddr,
  input  logic [1:0]             walk_page_size,
  input  logic [2:0]             walk_perm,
  input  logic                   walk_fault,
  output logic                   walk_abort,
  input  logic                   flush_all
);

  ptw_arb_state_e         r_state, w_state_nxt;
  ptw_src_e               r_src, w_src_nxt;
  logic                   r_killed, w_killed_nxt;
  logic [VADDR_WIDTH-1:0] r_walk_vaddr, w_walk_vaddr_nxt;
  logic                   r_walk_req_valid, w_walk_req_valid_nxt;
  ptw_resp_t              r_resp, w_resp_nxt;
  logic                   r_itlb_ack, w_itlb_ack_nxt;
  logic                   r_dtlb_ack, w_dtlb_ack_nxt;
  logic [1:0]             w_req, w_gnt;
  logic                   w_arb_upd;
  logic                   w_kill;
`ifdef SUPERH16_PTW_TIMEOUT_EN
  logic [15:0]            r_timer, w_timer_nxt;
  logic                   r_abort, w_abort_nxt;
`endif

  assign w_req     = {dtlb_req, itlb_req};
  assign w_arb_upd = (r_state == IDLE) && !flush_all && (|w_gnt);
  assign w_kill    = r_killed || flush_all;

  superh16_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (w_req),
    .i_upd (w_arb_upd),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_state_nxt          = r_state;
    w_src_nxt            = r_src;
    w_killed_nxt         = r_killed;
    w_walk_vaddr_nxt     = r_walk_vaddr;
    w_walk_req_valid_nxt = r_walk_req_valid;
    w_resp_nxt           = r_resp;
    w_itlb_ack_nxt       = 1'b0;
    w_dtlb_ack_nxt       = 1'b0;
`ifdef SUPERH16_PTW_TIMEOUT_EN
    w_timer_nxt          = r_timer;
    w_abort_nxt          = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_arb_upd) begin
          w_src_nxt            = w_gnt[1] ? PTW_SRC_DTLB : PTW_SRC_ITLB;
          w_walk_vaddr_nxt     = w_gnt[1] ? dtlb_vaddr : itlb_vaddr;
          w_walk_req_valid_nxt = 1'b1;
          w_state_nxt          = ISSUE;
        end
      end
      ISSUE: begin
        if (flush_all)
          w_killed_nxt = 1'b1;
        if (walk_req_ready) begin
          w_walk_req_valid_nxt = 1'b0;
          w_state_nxt          = WAIT;
`ifdef SUPERH16_PTW_TIMEOUT_EN
          w_timer_nxt          = '0;
`endif
        end
      end
      WAIT: begin
        if (flush_all)
          w_killed_nxt = 1'b1;
        if (walk_resp_valid) begin
          w_resp_nxt.paddr     = walk_paddr;
          w_resp_nxt.page_size = walk_page_size;
          w_resp_nxt.perm      = walk_perm;
          w_resp_nxt.valid     = !walk_fault;
          w_state_nxt          = w_kill ? IDLE : RESP;
          w_itlb_ack_nxt       = !w_kill && (r_src == PTW_SRC_ITLB);
          w_dtlb_ack_nxt       = !w_kill && (r_src == PTW_SRC_DTLB);
        end
`ifdef SUPERH16_PTW_TIMEOUT_EN
        else if (r_timer == 16'(TIMEOUT_CYCLES - 1)) begin
          w_abort_nxt      = 1'b1;
          w_resp_nxt.valid = 1'b0;
          w_state_nxt      = w_kill ? IDLE : RESP;
          w_itlb_ack_nxt   = !w_kill && (r_src == PTW_SRC_ITLB);
          w_dtlb_ack_nxt   = !w_kill && (r_src == PTW_SRC_DTLB);
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
`endif
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // killed covers exactly one walk; every path back to IDLE drops it
    if (w_state_nxt == IDLE)
      w_killed_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_src            <= PTW_SRC_ITLB;
      r_killed         <= 1'b0;
      r_walk_vaddr     <= '0;
      r_walk_req_valid <= 1'b0;
      r_resp           <= '0;
      r_itlb_ack       <= 1'b0;
      r_dtlb_ack       <= 1'b0;
`ifdef SUPERH16_PTW_TIMEOUT_EN
      r_timer          <= '0;
      r_abort          <= 1'b0;
`endif
    end else begin
      r_state          <= w_state_nxt;
      r_src            <= w_src_nxt;
      r_killed         <= w_killed_nxt;
      r_walk_vaddr     <= w_walk_vaddr_nxt;
      r_walk_req_valid <= w_walk_req_valid_nxt;
      r_resp           <= w_resp_nxt;
      r_itlb_ack       <= w_itlb_ack_nxt;
      r_dtlb_ack       <= w_dtlb_ack_nxt;
`ifdef SUPERH16_PTW_TIMEOUT_EN
      r_timer          <= w_timer_nxt;
      r_abort          <= w_abort_nxt;
`endif
    end
  end

  assign itlb_ack       = r_itlb_ack;
  assign dtlb_ack       = r_dtlb_ack;
  assign resp_paddr     = r_resp.paddr;
  assign resp_page_size = r_resp.page_size;
  assign resp_perm      = r_resp.perm;
  assign resp_valid     = r_resp.valid;
  assign walk_req_valid = r_walk_req_valid;
  assign walk_vaddr     = r_walk_vaddr;
`ifdef SUPERH16_PTW_TIMEOUT_EN
  assign walk_abort     = r_abort;
`else
  assign walk_abort     = 1'b0;
`endif

endmodule

// File: tb/tb_superh16_ptw_arbiter.sv
// Self-checking bench for superh16_ptw_arbiter; a scoreboard of expected acks is drained by a monitor.
module tb_superh16_ptw_arbiter;
  import superh16_ptw_arbiter_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   itlb_req, dtlb_req, itlb_ack, dtlb_ack, flush_all;
  logic [VADDR_WIDTH-1:0] itlb_vaddr, dtlb_vaddr;
  logic [PADDR_WIDTH-1:0] resp_paddr;
  logic [1:0]             resp_page_size;
  logic [2:0]             resp_perm;
  logic                   resp_valid;

  always #5 clk = ~clk;

  superh16_ptw_arbiter_if wif ();

  superh16_ptw_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .itlb_req        (itlb_req),
    .itlb_vaddr      (itlb_vaddr),
    .itlb_ack        (itlb_ack),
    .dtlb_req        (dtlb_req),
    .dtlb_vaddr      (dtlb_vaddr),
    .dtlb_ack        (dtlb_ack),
    .resp_paddr      (resp_paddr),
    .resp_page_size  (resp_page_size),
    .resp_valid      (resp_valid),
    .resp_perm       (resp_perm),
    .walk_req_valid  (wif.walk_req_valid),
    .walk_req_ready  (wif.walk_req_ready),
    .walk_vaddr      (wif.walk_vaddr),
    .walk_resp_valid (wif.walk_resp_valid),
    .walk_paddr      (wif.walk_paddr),
    .walk_page_size  (wif.walk_page_size),
    .walk_perm       (wif.walk_perm),
    .walk_fault      (wif.walk_fault),
    .walk_abort      (wif.walk_abort),
    .flush_all       (flush_all)
  );

  typedef struct {
    ptw_src_e               src;
    logic [PADDR_WIDTH-1:0] paddr;
    logic [1:0]             size;
    logic [2:0]             perm;
    logic                   valid;
    bit                     chk_data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin : ack_monitor
    exp_t     e;
    ptw_src_e got;
    if (rst_n && (itlb_ack || dtlb_ack)) begin
      checks++;
      if (itlb_ack && dtlb_ack) begin
        errors++;
        $display("FAIL ack_onehot itlb_ack=%b dtlb_ack=%b required exactly one", itlb_ack, dtlb_ack);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected itlb_ack=%b dtlb_ack=%b required no ack", itlb_ack, dtlb_ack);
      end else begin
        e   = sb.pop_front();
        got = dtlb_ack ? PTW_SRC_DTLB : PTW_SRC_ITLB;
        if (got !== e.src) begin
          errors++;
          $display("FAIL sb_src got=%s required=%s", got.name(), e.src.name());
        end
        checks++;
        if (resp_valid !== e.valid) begin
          errors++;
          $display("FAIL sb_valid got=%b required=%b", resp_valid, e.valid);
        end
        if (e.chk_data) begin
          checks++;
          if ({resp_paddr, resp_page_size, resp_perm} !== {e.paddr, e.size, e.perm}) begin
            errors++;
            $display("FAIL sb_data got=%h/%b/%b required=%h/%b/%b",
                     resp_paddr, resp_page_size, resp_perm, e.paddr, e.size, e.perm);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input int maxc, output int n);
    n = 0;
    while (wif.walk_req_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    checks++;
    if (wif.walk_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL issue_timeout walk_req_valid=%b required 1 within %0d cycles", wif.walk_req_valid, maxc);
    end
  endtask

  task automatic give_resp(input ptw_src_e src, input logic [PADDR_WIDTH-1:0] pa, input logic [1:0] sz,
                           input logic [2:0] pm, input logic flt, input int lat, input bit kill);
    exp_t       e;
    logic [1:0] exp_ack;
    tick();
    checks++;
    if (wif.walk_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL req_drop walk_req_valid=%b required 0 after handshake", wif.walk_req_valid);
    end
    repeat (lat) tick();
    wif.walk_resp_valid = 1'b1;
    wif.walk_paddr      = pa;
    wif.walk_page_size  = sz;
    wif.walk_perm       = pm;
    wif.walk_fault      = flt;
    if (kill) begin
      flush_all = 1'b1;
    end else begin
      e.src = src; e.paddr = pa; e.size = sz; e.perm = pm; e.valid = !flt; e.chk_data = 1'b1;
      sb.push_back(e);
    end
    tick();
    wif.walk_resp_valid = 1'b0;
    wif.walk_fault      = 1'b0;
    flush_all           = 1'b0;
    exp_ack = kill ? 2'b00 : ((src == PTW_SRC_ITLB) ? 2'b10 : 2'b01);
    checks++;
    if ({itlb_ack, dtlb_ack} !== exp_ack) begin
      errors++;
      $display("FAIL ack_route {itlb,dtlb}_ack=%b required=%b", {itlb_ack, dtlb_ack}, exp_ack);
    end
  endtask

  task automatic test_reset();
    int n;
    itlb_req = 0; dtlb_req = 0; flush_all = 0; itlb_vaddr = '0; dtlb_vaddr = '0;
    wif.walk_req_ready = 1; wif.walk_resp_valid = 0; wif.walk_paddr = '0;
    wif.walk_page_size = '0; wif.walk_perm = '0; wif.walk_fault = 0;
    rst_n = 0;
    repeat (2) tick();
    checks++;
    if ({itlb_ack, dtlb_ack, resp_valid, resp_paddr, resp_page_size, resp_perm,
         wif.walk_req_valid, wif.walk_vaddr, wif.walk_abort} !== '0) begin
      errors++;
      $display("FAIL reset_outputs walk_vaddr=%h req_valid=%b required all 0", wif.walk_vaddr, wif.walk_req_valid);
    end
    rst_n = 1;
    itlb_req = 1; itlb_vaddr = 48'h0000_1111_2000;
    wait_issue(4, n);
    tick(); tick();
    rst_n = 0;
    #1;
    checks++;
    if ({itlb_ack, dtlb_ack, resp_valid, wif.walk_req_valid, wif.walk_vaddr, wif.walk_abort} !== '0) begin
      errors++;
      $display("FAIL reset_midwait walk_vaddr=%h req_valid=%b required all 0", wif.walk_vaddr, wif.walk_req_valid);
    end
    tick();
    rst_n = 1;
    tick();
    checks++;
    if (wif.walk_req_valid !== 1'b1 || wif.walk_vaddr !== itlb_vaddr) begin
      errors++;
      $display("FAIL reset_regrant valid=%b vaddr=%h required 1/%h", wif.walk_req_valid, wif.walk_vaddr, itlb_vaddr);
    end
    give_resp(PTW_SRC_ITLB, 40'h12_3456_7000, 2'b00, 3'b001, 1'b0, 0, 1'b0);
    itlb_req = 0;
    tick();
  endtask

  task automatic test_lone_itlb();
    int n;
    itlb_req = 1; itlb_vaddr = 48'h0000_4000_1234;
    wait_issue(4, n);
    checks++;
    if (wif.walk_vaddr !== 48'h0000_4000_1234) begin
      errors++;
      $display("FAIL lone_vaddr got=%h required=%h", wif.walk_vaddr, 48'h0000_4000_1234);
    end
    give_resp(PTW_SRC_ITLB, 40'h8_0000_1000, 2'b00, 3'b101, 1'b0, 2, 1'b0);
    itlb_req = 0;
    checks++;
    if (resp_valid !== 1'b1 || resp_perm !== 3'b101 || resp_paddr !== 40'h8_0000_1000) begin
      errors++;
      $display("FAIL lone_resp valid=%b perm=%b paddr=%h required 1/101/%h", resp_valid, resp_perm, resp_paddr, 40'h8_0000_1000);
    end
    tick();
    checks++;
    if ({itlb_ack, dtlb_ack} !== 2'b00) begin
      errors++;
      $display("FAIL lone_pulse {itlb,dtlb}_ack=%b required 00", {itlb_ack, dtlb_ack});
    end
    tick();
    checks++;
    if (resp_perm !== 3'b101 || resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_hold perm=%b valid=%b required 101/1", resp_perm, resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int       n;
    ptw_src_e s;
    itlb_req = 1; dtlb_req = 1;
    itlb_vaddr = 48'h0000_0000_A000; dtlb_vaddr = 48'h0000_0000_D000;
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      wait_issue(4, n);
      s = (i % 2 == 1) ? PTW_SRC_DTLB : PTW_SRC_ITLB;
      checks++;
      if (wif.walk_vaddr !== ((s == PTW_SRC_ITLB) ? itlb_vaddr : dtlb_vaddr)) begin
        errors++;
        $display("FAIL rr_order walk %0d vaddr=%h required src %s", i, wif.walk_vaddr, s.name());
      end
      if (i > 0) begin
        checks++;
        if (n != 2) begin
          errors++;
          $display("FAIL rr_turnaround walk %0d cycles=%0d required 2", i, n);
        end
      end
      give_resp(s, 40'h00_0010_0000 + 40'(i), 2'b01, 3'b011, 1'b0, 1, 1'b0);
    end
    itlb_req = 0; dtlb_req = 0;
    tick();
  endtask

  task automatic test_flush();
    int n;
    itlb_vaddr = 48'h0000_0000_F000;
    itlb_req = 1; flush_all = 1;
    tick();
    flush_all = 0;
    checks++;
    if (wif.walk_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle walk_req_valid=%b required 0", wif.walk_req_valid);
    end
    wait_issue(4, n);
    tick(); tick();
    flush_all = 1;
    tick();
    flush_all = 0;
    tick();
    wif.walk_resp_valid = 1; wif.walk_paddr = 40'h77_0000_0000;
    tick();
    wif.walk_resp_valid = 0;
    checks++;
    if ({itlb_ack, dtlb_ack} !== 2'b00) begin
      errors++;
      $display("FAIL flush_wait_ack {itlb,dtlb}_ack=%b required 00", {itlb_ack, dtlb_ack});
    end
    tick();
    checks++;
    if (wif.walk_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_regrant walk_req_valid=%b required 1 two cycles after resp", wif.walk_req_valid);
    end
    give_resp(PTW_SRC_ITLB, 40'h55_0000_0000, 2'b10, 3'b111, 1'b0, 1, 1'b1);
    wif.walk_req_ready = 0;
    wait_issue(4, n);
    flush_all = 1;
    tick();
    flush_all = 0;
    checks++;
    if (wif.walk_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_issue walk_req_valid=%b required 1 held", wif.walk_req_valid);
    end
    wif.walk_req_ready = 1;
    tick(); tick();
    wif.walk_resp_valid = 1;
    tick();
    wif.walk_resp_valid = 0;
    itlb_req = 0;
    checks++;
    if ({itlb_ack, dtlb_ack} !== 2'b00) begin
      errors++;
      $display("FAIL flush_issue_ack {itlb,dtlb}_ack=%b required 00", {itlb_ack, dtlb_ack});
    end
    tick();
  endtask

  task automatic test_fault();
    int n;
    dtlb_req = 1; dtlb_vaddr = 48'h0000_0BAD_0000;
    wait_issue(4, n);
    dtlb_req = 0;
    give_resp(PTW_SRC_DTLB, 40'h00_0BAD_0000, 2'b01, 3'b011, 1'b1, 2, 1'b0);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_valid resp_valid=%b required 0", resp_valid);
    end
    tick();
    wif.walk_resp_valid = 1;
    tick();
    wif.walk_resp_valid = 0;
    tick();
    checks++;
    if ({itlb_ack, dtlb_ack, wif.walk_req_valid} !== 3'b000) begin
      errors++;
      $display("FAIL stray_resp {itlb,dtlb,req_valid}=%b required 000", {itlb_ack, dtlb_ack, wif.walk_req_valid});
    end
  endtask

  task automatic test_timeout();
    int   n;
    exp_t e;
`ifdef SUPERH16_PTW_TIMEOUT_EN
    dtlb_req = 1; dtlb_vaddr = 48'h0000_0000_7000;
    wait_issue(4, n);
    dtlb_req = 0;
    e.src = PTW_SRC_DTLB; e.paddr = '0; e.size = '0; e.perm = '0; e.valid = 1'b0; e.chk_data = 1'b0;
    sb.push_back(e);
    tick();
    n = 0;
    while (wif.walk_abort !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL abort_time cycles=%0d required 16", n);
    end
    checks++;
    if ({itlb_ack, dtlb_ack} !== 2'b01) begin
      errors++;
      $display("FAIL abort_ack {itlb,dtlb}_ack=%b required 01", {itlb_ack, dtlb_ack});
    end
    tick();
    checks++;
    if (wif.walk_abort !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse walk_abort=%b required 0", wif.walk_abort);
    end
    wif.walk_resp_valid = 1;
    tick();
    wif.walk_resp_valid = 0;
    tick();
    checks++;
    if ({itlb_ack, dtlb_ack} !== 2'b00) begin
      errors++;
      $display("FAIL late_resp {itlb,dtlb}_ack=%b required 00", {itlb_ack, dtlb_ack});
    end
`else
    bit seen;
    itlb_req = 1; itlb_vaddr = 48'h0000_0000_9000;
    wait_issue(4, n);
    itlb_req = 0;
    tick();
    seen = 0;
    repeat (1000) begin
      tick();
      if (itlb_ack || dtlb_ack || wif.walk_abort || wif.walk_req_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout activity=%b required 0 over 1000 WAIT cycles", seen);
    end
    e.src = PTW_SRC_ITLB; e.paddr = 40'h00_0000_9000; e.size = 2'b00; e.perm = 3'b100; e.valid = 1'b1; e.chk_data = 1'b1;
    sb.push_back(e);
    wif.walk_resp_valid = 1; wif.walk_paddr = e.paddr; wif.walk_page_size = e.size; wif.walk_perm = e.perm;
    tick();
    wif.walk_resp_valid = 0;
    checks++;
    if (itlb_ack !== 1'b1) begin
      errors++;
      $display("FAIL wait_unbounded itlb_ack=%b required 1", itlb_ack);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_lone_itlb();
    test_round_robin();
    test_flush();
    test_fault();
    test_timeout();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
